fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a decoupling prefetch queue. It generates sequential fetch addresses toward instruction memory and honours the `iready_n` wait handshake. Fetched instructions are buffered with their PCs, and a `{insn, pc, pc+4}` triple is presented to the IF/ID boundary. Two redirect sources (early branch from ID, late branch from EX) flush the queue and restart fetch. Stall and bubble controls come from the hazard unit.

---
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a decoupling prefetch queue feeding the IF/ID boundary.
// Sequential fetch with an iready_n wait handshake. Late/early redirects flush the queue and restart fetch.
module fetch_queue #(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0001_0000),
   parameter logic [XLEN-1:0]  NOP_INSN = XLEN'(32'h0000_0013)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      bubble,
   input  logic                      redir_early_valid,
   input  logic [XLEN-1:0]           redir_early_pc,
   input  logic                      redir_late_valid,
   input  logic [XLEN-1:0]           redir_late_pc,
   output logic [XLEN-1:0]           iaddr,
   output logic                      ireq,
   input  logic                      iready_n,
   input  logic [XLEN-1:0]           idata,
   output logic                      out_valid,
   output logic [XLEN-1:0]           out_insn,
   output logic [XLEN-1:0]           out_pc,
   output logic [XLEN-1:0]           out_pcp4,
   output logic [4:0]                out_rs1,
   output logic [4:0]                out_rs2,
   output logic [$clog2(DEPTH):0]    q_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] insn_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];

   logic [PW-1:0]   head_p0;
   logic [PW-1:0]   tail_p0;
   logic [CW-1:0]   count_p0;

   logic            full;
   logic            empty;
   logic            redir;
   logic [XLEN-1:0] redir_pc;
   logic            push;
   logic            pop;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

   assign full     = (count_p0 == CW'(DEPTH));
   assign empty    = (count_p0 == '0);
   assign redir    = redir_early_valid | redir_late_valid;
   assign redir_pc = redir_late_valid ? redir_late_pc : redir_early_pc;

   // Full is taken from the registered count, so a pop never frees a slot for a same-cycle push.
   assign ireq      = rst & ~full;
   assign push      = ireq & ~iready_n & ~redir;
   assign out_valid = ~empty & ~bubble;
   assign pop       = out_valid & ~stall & ~redir;

   // Fetch address and queue control
   always_ff @(posedge clk) begin
      if (!rst) begin
         iaddr    <= RESET_PC;
         head_p0  <= '0;
         tail_p0  <= '0;
         count_p0 <= '0;
      end else if (redir) begin
         iaddr    <= redir_pc;
         head_p0  <= '0;
         tail_p0  <= '0;
         count_p0 <= '0;
      end else begin
         if (push) begin
            iaddr   <= pc_next(iaddr);
            tail_p0 <= tail_p0 + PW'(1);
         end
         if (pop) begin
            head_p0 <= head_p0 + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_p0 <= count_p0 + CW'(1);
            2'b01:   count_p0 <= count_p0 - CW'(1);
            default: count_p0 <= count_p0;
         endcase
      end
   end

   // Queue storage
   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem[tail_p0] <= idata;
         pc_mem[tail_p0]   <= iaddr;
      end
   end

   // IF/ID presentation: an empty queue shows the pending fetch address.
   assign out_insn = out_valid ? insn_mem[head_p0] : NOP_INSN;
   assign out_pc   = empty ? iaddr : pc_mem[head_p0];
   assign out_pcp4 = pc_next(out_pc);
   assign out_rs1  = out_insn[19:15];
   assign out_rs2  = out_insn[24:20];
   assign q_count  = count_p0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scoreboard of fetched {pc, insn} plus directed scenario checks.
module tb_fetch_queue;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0001_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        bubble;
   logic        redir_early_valid;
   logic [31:0] redir_early_pc;
   logic        redir_late_valid;
   logic [31:0] redir_late_pc;
   logic [31:0] iaddr;
   logic        ireq;
   logic        iready_n;
   logic [31:0] idata;
   logic        out_valid;
   logic [31:0] out_insn;
   logic [31:0] out_pc;
   logic [31:0] out_pcp4;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  q_count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] m_addr;
   int          vecs;
   int          errs;

   always #5 clk = ~clk;

   // Memory model: each word is its address with the upper half inverted.
   assign idata = iaddr ^ 32'hFFFF_0000;

   fetch_queue #(
      .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSN(NOP)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
      .redir_early_valid(redir_early_valid), .redir_early_pc(redir_early_pc),
      .redir_late_valid(redir_late_valid), .redir_late_pc(redir_late_pc),
      .iaddr(iaddr), .ireq(ireq), .iready_n(iready_n), .idata(idata),
      .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc), .out_pcp4(out_pcp4),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .q_count(q_count)
   );

   // One clock: compare against the model at the falling edge, advance the model at the rising edge.
   task automatic tick();
      logic        e_ireq, e_valid, redir, push, pop;
      logic [31:0] e_pc, e_insn;
      @(negedge clk);
      e_ireq  = rst & (sb.size() != DEPTH);
      redir   = redir_early_valid | redir_late_valid;
      push    = e_ireq & ~iready_n & ~redir;
      e_valid = (sb.size() != 0) & ~bubble;
      pop     = e_valid & ~stall & ~redir;
      e_pc    = (sb.size() != 0) ? sb[0].pc : m_addr;
      e_insn  = e_valid ? sb[0].insn : NOP;
      vecs++; if (iaddr !== m_addr) begin errs++; $display("FAIL sb_iaddr: got %h want %h", iaddr, m_addr); end
      vecs++; if (ireq !== e_ireq) begin errs++; $display("FAIL sb_ireq: got %b want %b", ireq, e_ireq); end
      vecs++; if (q_count !== 3'(sb.size())) begin errs++; $display("FAIL sb_count: got %0d want %0d", q_count, sb.size()); end
      vecs++; if (out_valid !== e_valid) begin errs++; $display("FAIL sb_valid: got %b want %b", out_valid, e_valid); end
      vecs++; if (out_pc !== e_pc) begin errs++; $display("FAIL sb_pc: got %h want %h", out_pc, e_pc); end
      vecs++; if (out_insn !== e_insn) begin errs++; $display("FAIL sb_insn: got %h want %h", out_insn, e_insn); end
      vecs++; if (out_pcp4 !== e_pc + 32'd4) begin errs++; $display("FAIL sb_pcp4: got %h want %h", out_pcp4, e_pc + 32'd4); end
      vecs++; if (out_rs1 !== e_insn[19:15] || out_rs2 !== e_insn[24:20]) begin
         errs++; $display("FAIL sb_rs: got %h/%h want %h/%h", out_rs1, out_rs2, e_insn[19:15], e_insn[24:20]);
      end
      @(posedge clk);
      if (!rst) begin
         sb.delete();
         m_addr = RPC;
      end else if (redir) begin
         sb.delete();
         m_addr = redir_late_valid ? redir_late_pc : redir_early_pc;
      end else begin
         if (pop) void'(sb.pop_front());
         if (push) begin
            sb.push_back('{pc: m_addr, insn: m_addr ^ 32'hFFFF_0000});
            m_addr = m_addr + 32'd4;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; stall = 1'b0; bubble = 1'b0; iready_n = 1'b0;
      redir_early_valid = 1'b0; redir_late_valid = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      vecs++; if (iaddr !== RPC) begin errs++; $display("FAIL rst_iaddr: got %h want %h", iaddr, RPC); end
      vecs++; if (q_count !== 3'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", q_count); end
      vecs++; if (out_valid !== 1'b0 || out_insn !== NOP) begin
         errs++; $display("FAIL rst_out: got %b/%h want 0/%h", out_valid, out_insn, NOP);
      end
      vecs++; if (out_pc !== RPC || out_pcp4 !== 32'h0001_0004) begin
         errs++; $display("FAIL rst_pc: got %h/%h want %h/00010004", out_pc, out_pcp4, RPC);
      end
   endtask

   task automatic test_stream();
      tick();
      vecs++; if (iaddr !== 32'h0001_0004) begin errs++; $display("FAIL stream_iaddr: got %h want 00010004", iaddr); end
      vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h0001_0000 || out_insn !== 32'hFFFE_0000 || out_pcp4 !== 32'h0001_0004) begin
         errs++; $display("FAIL stream_first: got %b %h %h %h want 1 00010000 fffe0000 00010004", out_valid, out_pc, out_insn, out_pcp4);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         vecs++; if (iaddr !== 32'h0001_0008 + 32'(4 * i) || q_count !== 3'd1) begin
            errs++; $display("FAIL stream_steady: got %h/%0d want %h/1", iaddr, q_count, 32'h0001_0008 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_stall_fill();
      apply_reset();
      stall = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      vecs++; if (q_count !== 3'd4 || ireq !== 1'b0) begin errs++; $display("FAIL fill_full: got %0d/%b want 4/0", q_count, ireq); end
      vecs++; if (iaddr !== 32'h0001_0010 || out_pc !== 32'h0001_0000) begin
         errs++; $display("FAIL fill_hold: got %h/%h want 00010010/00010000", iaddr, out_pc);
      end
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h0001_0000 + 32'(4 * i)) begin
            errs++; $display("FAIL fill_drain: got %b/%h want 1/%h", out_valid, out_pc, 32'h0001_0000 + 32'(4 * i));
         end
         tick();
      end
   endtask

   task automatic test_mem_wait();
      logic [31:0] held;
      for (int i = 0; i < 3; i++) tick();
      held = m_addr;
      iready_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++; if (iaddr !== held) begin errs++; $display("FAIL wait_hold: got %h want %h", iaddr, held); end
      end
      iready_n = 1'b0;
      tick();
      vecs++; if (out_valid !== 1'b1 || out_pc !== held) begin
         errs++; $display("FAIL wait_resume: got %b/%h want 1/%h", out_valid, out_pc, held);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_redirect_collision();
      stall = 1'b1;
      tick();
      tick();
      vecs++; if (q_count !== 3'd3) begin errs++; $display("FAIL coll_fill: got %0d want 3", q_count); end
      redir_early_valid = 1'b1; redir_early_pc = 32'h0000_2000;
      redir_late_valid  = 1'b1; redir_late_pc  = 32'h0000_3000;
      tick();
      redir_early_valid = 1'b0; redir_late_valid = 1'b0;
      vecs++; if (q_count !== 3'd0 || iaddr !== 32'h0000_3000 || out_valid !== 1'b0) begin
         errs++; $display("FAIL coll_flush: got %0d/%h/%b want 0/00003000/0", q_count, iaddr, out_valid);
      end
      stall = 1'b0;
      tick();
      vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_3000 || out_insn !== 32'hFFFF_3000) begin
         errs++; $display("FAIL coll_first: got %b/%h/%h want 1/00003000/ffff3000", out_valid, out_pc, out_insn);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_bubble();
      apply_reset();
      for (int i = 0; i < 3; i++) tick();
      bubble = 1'b1;
      #1;
      vecs++; if (out_valid !== 1'b0 || out_insn !== NOP || out_pc !== 32'h0001_0008) begin
         errs++; $display("FAIL bubble_nop: got %b/%h/%h want 0/%h/00010008", out_valid, out_insn, out_pc, NOP);
      end
      tick();
      bubble = 1'b0;
      #1;
      vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h0001_0008 || out_insn !== 32'hFFFE_0008) begin
         errs++; $display("FAIL bubble_next: got %b/%h/%h want 1/00010008/fffe0008", out_valid, out_pc, out_insn);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_wrap();
      redir_late_valid = 1'b1; redir_late_pc = 32'hFFFF_FFFC;
      tick();
      redir_late_valid = 1'b0;
      vecs++; if (iaddr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_target: got %h want fffffffc", iaddr); end
      tick();
      vecs++; if (iaddr !== 32'h0000_0000 || out_pc !== 32'hFFFF_FFFC || out_pcp4 !== 32'h0000_0000) begin
         errs++; $display("FAIL wrap_pc: got %h/%h/%h want 00000000/fffffffc/00000000", iaddr, out_pc, out_pcp4);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset_mid();
      stall = 1'b1;
      tick();
      tick();
      rst = 1'b0; bubble = 1'b1;
      redir_early_valid = 1'b1; redir_early_pc = 32'h0000_4000;
      tick();
      redir_early_valid = 1'b0; bubble = 1'b0; stall = 1'b0;
      vecs++; if (iaddr !== RPC || q_count !== 3'd0 || ireq !== 1'b0) begin
         errs++; $display("FAIL midrst_state: got %h/%0d/%b want %h/0/0", iaddr, q_count, ireq, RPC);
      end
      vecs++; if (out_valid !== 1'b0 || out_insn !== NOP || out_pcp4 !== 32'h0001_0004) begin
         errs++; $display("FAIL midrst_out: got %b/%h/%h want 0/%h/00010004", out_valid, out_insn, out_pcp4, NOP);
      end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      vecs = 0; errs = 0;
      m_addr = RPC;
      redir_early_pc = '0; redir_late_pc = '0;
      test_reset();
      test_stream();
      test_stall_fill();
      test_mem_wait();
      test_redirect_collision();
      test_bubble();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
